data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit storage words (power of 2, 4..1024).
REQ-002 SHALL have parameter READ_LAT, default 2, meaning the cycles from read acceptance to response (1..7).
REQ-003 SHALL use one clock, clk, with reset rst_n asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state and storage.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  input  1  initiator presents a request.
REQ-007 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-008 SHALL have port MemRead  input  1  request is a word read.
REQ-009 SHALL have port MemWrite  input  1  request is a write.
REQ-010 SHALL have port Address  input  32  byte address.
REQ-011 SHALL have port WriteData  input  32  write data.
REQ-012 SHALL have port byte_en  input  4  write byte lanes (bit i = WriteData[8i+7:8i]).
REQ-013 SHALL have port rsp_valid  output  1  one-cycle response strobe.
REQ-014 SHALL have port ReadData  output  32  read data, valid only with rsp_valid.
REQ-015 SHALL have port rsp_err  output  1  request rejected, valid only with rsp_valid.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = (state == IDLE).
REQ-017 SHALL accept a request at a rising edge where req_valid and req_ready are both 1; request inputs are sampled only at that edge.
REQ-018 SHALL flag an error request when any of these holds: Address[1:0] != 0; word index Address[31:2] >= DEPTH_WORDS; MemRead == MemWrite.
REQ-019 SHALL, for an error request, leave storage unchanged and go IDLE->RESP, giving rsp_valid=1, rsp_err=1, ReadData=0 in the cycle after acceptance.
REQ-020 SHALL, for a legal write, update only the lanes enabled by byte_en at the acceptance edge, then go IDLE->RESP with rsp_err=0 and ReadData=0.
REQ-021 SHALL treat a legal write with byte_en=4'b0000 as a successful no-op.
REQ-022 SHALL, for a legal read, latch the word index and go IDLE->WAIT, count READ_LAT-1 cycles, then go to RESP; rsp_valid is high in the cycle beginning READ_LAT edges after acceptance; READ_LAT=1 goes IDLE->RESP directly.
REQ-023 SHALL ignore byte_en on reads and return the full 32-bit word.
REQ-024 SHALL return the stored word as of the acceptance edge; a write accepted earlier is visible to any later read.
REQ-025 SHALL hold rsp_valid for exactly one cycle (no backpressure) and then return RESP->IDLE; the next acceptance is possible at the edge ending the RESP cycle.
REQ-026 SHALL ignore req_valid whenever the state is not IDLE; no request is queued.
REQ-027 SHALL drive ReadData=0 and rsp_err=0 whenever rsp_valid=0.

Reset
REQ-028 SHALL, on rst_n low, immediately force state=IDLE, wait counter=0, rsp_valid=0, rsp_err=0, ReadData=0, and req_ready=0 while rst_n is low.
REQ-029 SHALL leave storage contents unaffected by reset; storage initializes to all zeros at time zero.
REQ-030 SHALL discard a read pending in WAIT when reset asserts, with no rsp_valid after reset release.
REQ-031 SHALL assert req_ready=1 in the first cycle after rst_n deasserts.

Verification
REQ-032 SHALL cover write then read: write 0xDEADBEEF to 0x10 with byte_en=1111, then read 0x10 -> write rsp 1 cycle after acceptance (err=0); read rsp READ_LAT=2 cycles after acceptance with ReadData=0xDEADBEEF.
REQ-033 SHALL cover partial write: word 0x10=0xDEADBEEF, write 0x00001122 with byte_en=0011, then read -> 0xDEAD1122.
REQ-034 SHALL cover errors: read 0x13, write 0x400 (DEPTH=256), and MemRead=MemWrite=1 at 0x0 -> each gives rsp_err=1 and ReadData=0 one cycle later; word 0x0 is unchanged.
REQ-035 SHALL cover back-to-back requests: req_valid held high with two reads -> req_ready=0 during WAIT/RESP; second acceptance exactly READ_LAT+1 cycles after the first; exactly two rsp_valid pulses.
REQ-036 SHALL cover reset mid-read: rst_n low during WAIT -> no rsp_valid; req_ready=1 in the first cycle after release; a prior write is still readable.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response bus between an initiator and the data memory responder
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic [3:0]  byte_en;
   logic        rsp_valid;
   logic [31:0] ReadData;
   logic        rsp_err;

   modport master (
      output req_valid, MemRead, MemWrite, Address, WriteData, byte_en,
      input  req_ready, rsp_valid, ReadData, rsp_err
   );

   modport slave (
      input  req_valid, MemRead, MemWrite, Address, WriteData, byte_en,
      output req_ready, rsp_valid, ReadData, rsp_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding word memory with byte-lane writes and fixed read latency
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int READ_LAT    = 2
) (
   input  logic clk,
   input  logic rst_n,
   data_mem_responder_if.slave bus
);

   localparam int IDX_W     = $clog2(DEPTH_WORDS);
   // WAIT lasts READ_LAT-1 cycles; the counter runs from READ_LAT-2 down to 0
   localparam int WAIT_INIT = (READ_LAT > 1) ? READ_LAT - 2 : 0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state;
   state_t            state_next;
   logic [2:0]        wait_cnt;
   logic [31:0]       rd_word;
   logic              err_q;
   logic [31:0]       mem [DEPTH_WORDS] = '{default: '0};

   logic              accept;
   logic              req_err;
   logic              is_read;
   logic              is_write;
   logic [IDX_W-1:0]  idx;

   // Request decode; the word index is only meaningful when req_err is low
   assign accept   = bus.req_valid && bus.req_ready;
   assign idx      = bus.Address[IDX_W+1:2];
   assign req_err  = (bus.Address[1:0] != 2'b00)
                  || (bus.Address[31:2] >= 30'(DEPTH_WORDS))
                  || (bus.MemRead == bus.MemWrite);
   assign is_read  = !req_err && bus.MemRead;
   assign is_write = !req_err && bus.MemWrite;

   // Ready is forced low while reset is held so nothing is accepted during reset
   assign bus.req_ready = (state == IDLE) && rst_n;
   assign bus.rsp_valid = (state == RESP);
   assign bus.ReadData  = (state == RESP) ? rd_word : 32'h0;
   assign bus.rsp_err   = (state == RESP) && err_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state: reads detour through WAIT when the latency exceeds one cycle
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = (is_read && READ_LAT > 1) ? WAIT : RESP;
         WAIT: if (wait_cnt == 3'd0) state_next = RESP;
         RESP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Wait counter and response payload, captured at acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= 3'd0;
         rd_word  <= 32'h0;
         err_q    <= 1'b0;
      end else if (accept) begin
         wait_cnt <= 3'(WAIT_INIT);
         rd_word  <= is_read ? mem[idx] : 32'h0;
         err_q    <= req_err;
      end else if (state == WAIT && wait_cnt != 3'd0) begin
         wait_cnt <= wait_cnt - 3'd1;
      end
   end

   // Storage write; deliberately outside reset so contents survive it
   always_ff @(posedge clk) begin
      if (accept && is_write) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.byte_en[i]) mem[idx][8*i +: 8] <= bus.WriteData[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder
module tb_data_mem_responder;

   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   pushed = 0;
   int   pulses = 0;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          acc;
      int          lat;
   } exp_t;

   exp_t sb[$];

   data_mem_responder_if bus ();

   data_mem_responder #(.DEPTH_WORDS(256), .READ_LAT(LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Response monitor: pops the scoreboard on every rsp_valid pulse
   always @(negedge clk) begin
      if (bus.rsp_valid === 1'b1) begin
         pulses++;
         if (sb.size() == 0) begin
            check("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_data", bus.ReadData, e.data);
            check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
            check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
         end
      end else if (bus.ReadData !== 32'h0 || bus.rsp_err !== 1'b0) begin
         check("idle_outputs_zero", {bus.ReadData[31:1], bus.ReadData[0] | bus.rsp_err}, 32'h0);
      end
   end

   task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
      bus.MemRead   = rd;
      bus.MemWrite  = wr;
      bus.Address   = addr;
      bus.WriteData = wdata;
      bus.byte_en   = be;
      bus.req_valid = 1'b1;
   endtask

   task automatic send(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_data, input logic exp_err, input int lat);
      int n;
      n = 0;
      @(negedge clk);
      while (bus.req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
      drive(rd, wr, addr, wdata, be);
      @(posedge clk);
      #1;
      sb.push_back('{exp_data, exp_err, cyc - 1, lat});
      pushed++;
      bus.req_valid = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      if (n >= 20) check({tag, "_rsp_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      int acc1;
      int acc2;
      int busy;
      int n;

      bus.req_valid = 1'b0;
      bus.MemRead   = 1'b0;
      bus.MemWrite  = 1'b0;
      bus.Address   = 32'h0;
      bus.WriteData = 32'h0;
      bus.byte_en   = 4'h0;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_req_ready", {31'd0, bus.req_ready}, 32'd0);
      check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("reset_read_data", bus.ReadData, 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_release", {31'd0, bus.req_ready}, 32'd1);

      // Full write then read
      send("wr_full", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1);
      send("rd_full", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, LAT);

      // Partial write, read ignores byte_en
      send("wr_part", 1'b0, 1'b1, 32'h10, 32'h00001122, 4'h3, 32'h0, 1'b0, 1);
      send("rd_part", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD1122, 1'b0, LAT);

      // Lane 3 only, then a zero-lane no-op write
      send("wr_word0", 1'b0, 1'b1, 32'h0, 32'hA5A50001, 4'hF, 32'h0, 1'b0, 1);
      send("wr_lane3", 1'b0, 1'b1, 32'h14, 32'h77000000, 4'h8, 32'h0, 1'b0, 1);
      send("rd_lane3", 1'b1, 1'b0, 32'h14, 32'h0, 4'hF, 32'h77000000, 1'b0, LAT);
      send("wr_noop", 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 1);
      send("rd_noop", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD1122, 1'b0, LAT);

      // Error requests and boundary words
      send("err_misalign", 1'b1, 1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1, 1);
      send("err_range", 1'b0, 1'b1, 32'h400, 32'h12345678, 4'hF, 32'h0, 1'b1, 1);
      send("err_both", 1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1);
      send("err_neither", 1'b0, 1'b0, 32'h0, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1);
      send("rd_word0", 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'hA5A50001, 1'b0, LAT);
      send("wr_last", 1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1);
      send("rd_last", 1'b1, 1'b0, 32'h3FC, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, LAT);

      // Back-to-back reads with req_valid held high
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      @(posedge clk);
      #1;
      acc1 = cyc;
      sb.push_back('{32'hDEAD1122, 1'b0, cyc - 1, LAT});
      pushed++;
      bus.Address = 32'h0;
      busy = 0;
      n = 0;
      @(negedge clk);
      while (bus.req_ready !== 1'b1 && n < 20) begin
         busy++;
         n++;
         @(negedge clk);
      end
      check("b2b_busy_cycles", 32'(busy), 32'(LAT));
      @(posedge clk);
      #1;
      acc2 = cyc;
      sb.push_back('{32'hA5A50001, 1'b0, cyc - 1, LAT});
      pushed++;
      bus.req_valid = 1'b0;
      check("b2b_accept_gap", 32'(acc2 - acc1), 32'(LAT + 1));
      repeat (LAT + 2) @(negedge clk);
      check("b2b_drained", 32'(sb.size()), 32'd0);

      // Reset while a read sits in WAIT
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_ready_low", {31'd0, bus.req_ready}, 32'd0);
      check("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_ready_after", {31'd0, bus.req_ready}, 32'd1);
      repeat (5) @(negedge clk);
      send("rd_after_rst", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD1122, 1'b0, LAT);

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      check("pulse_count", 32'(pulses), 32'(pushed));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
